pcode_seq_ctrl: RTL and testbench

Command-driven sequencer for the GPS P-code generator. It accepts a {satellite, word count} command, resets the generator for the new PRN, and clocks it one chip per enabled cycle. Chips are packed MSB-first into words on a valid/ready stream, and generator advance stalls under downstream backpressure so no chip is ever dropped. It sits between the host/DMA command interface and the pcode generator instance.

---
 rtl/gps_pkg.sv | 22 ++
 rtl/pcode_word_packer.sv | 51 +++++
 rtl/pcode_seq_ctrl.sv | 96 +++++++++
 tb/tb_pcode_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gps_pkg.sv
// Shared definitions for the GPS P-code sequencing blocks.
package gps_pkg;

  localparam int SAT_MAX        = 37;
  localparam int WORD_WIDTH_DEF = 32;
  localparam int SAT_WIDTH_DEF  = 6;
  localparam int LEN_WIDTH_DEF  = 24;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [SAT_WIDTH_DEF-1:0] sat;
    logic [LEN_WIDTH_DEF-1:0] len;
  } cmd_t;

endpackage

// File: rtl/pcode_word_packer.sv
// Packs generator chips MSB-first into words and holds each word on a valid/ready stream.
module pcode_word_packer #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chip_en,
  input  logic                  chip,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  word_done,
  output logic                  stall,
  output logic                  out_valid,
  output logic [WORD_WIDTH-1:0] out_data
);

  localparam int CW = $clog2(WORD_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WORD_WIDTH - 1);

  // Only WORD_WIDTH-1 chips ever need to wait here; the last one goes straight to out_data.
  logic [WORD_WIDTH-2:0] pack;
  logic [CW-1:0]         bit_cnt;

  assign word_done = chip_en & (bit_cnt == LAST);
  assign stall     = (bit_cnt == LAST) & out_valid & ~out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pack      <= '0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (chip_en) begin
        pack <= {pack[WORD_WIDTH-3:0], chip};
        if (bit_cnt == LAST) begin
          out_data <= {pack, chip};
          bit_cnt  <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      // A fresh word loading in the handshake cycle keeps valid high.
      if (word_done)
        out_valid <= 1'b1;
      else if (out_valid && out_ready)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pcode_seq_ctrl.sv
// Command sequencer: validates {sat, len}, restarts the P-code generator and streams packed words.
// Stream handshake: a word transfers on a cycle where out_valid & out_ready; out_data holds while out_valid & !out_ready.
module pcode_seq_ctrl
  import gps_pkg::*;
#(
  parameter int SAT_WIDTH  = SAT_WIDTH_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [SAT_WIDTH-1:0]  cmd_sat,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err_bad_cmd,
  output logic                  pcode_prn_changed,
  output logic                  pcode_en,
  output logic [SAT_WIDTH-1:0]  pcode_sat,
  input  logic                  pcode_preg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output state_t                dbg_state
);

  state_t               state, state_nx;
  logic [LEN_WIDTH-1:0] words_left;
  logic                 cmd_fire, cmd_good, flush, word_done, stall;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign cmd_good  = (cmd_sat != '0) && (cmd_sat <= SAT_WIDTH'(SAT_MAX)) && (cmd_len != '0);
  assign flush     = abort & (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_fire && cmd_good) state_nx = LOAD;
      LOAD:    state_nx = RUN;
      RUN:     if (word_done && words_left == LEN_WIDTH'(1)) state_nx = DRAIN;
      DRAIN:   if (out_valid && out_ready) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_comb begin
    cmd_ready         = (state == IDLE);
    busy              = (state != IDLE);
    pcode_prn_changed = (state == LOAD);
    pcode_en          = (state == RUN) & ~stall;
    done              = (state == DONE) & ~abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_left  <= '0;
      pcode_sat   <= '0;
      err_bad_cmd <= 1'b0;
    end else begin
      err_bad_cmd <= cmd_fire & ~cmd_good;
      if (flush) begin
        words_left <= '0;
      end else if (cmd_fire && cmd_good) begin
        words_left <= cmd_len;
        pcode_sat  <= cmd_sat;
      end else if (word_done && words_left != '0) begin
        words_left <= words_left - 1'b1;
      end
    end
  end

  pcode_word_packer #(.WORD_WIDTH(WORD_WIDTH)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .chip_en   (pcode_en),
    .chip      (pcode_preg),
    .flush     (flush),
    .out_ready (out_ready),
    .word_done (word_done),
    .stall     (stall),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_pcode_seq_ctrl.sv
// Directed bench for pcode_seq_ctrl with an LFSR stand-in for the P-code generator.
module tb_pcode_seq_ctrl;
  import gps_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready, abort, busy, done, err_bad_cmd;
  logic [5:0]  cmd_sat, pcode_sat;
  logic [23:0] cmd_len;
  logic        pcode_prn_changed, pcode_en, pcode_preg, out_valid, out_ready;
  logic [31:0] out_data;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  int prn_cnt = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [15:0] gen_l = 16'h0001;

  pcode_seq_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sat(cmd_sat), .cmd_len(cmd_len), .abort(abort), .busy(busy),
    .done(done), .err_bad_cmd(err_bad_cmd), .pcode_prn_changed(pcode_prn_changed),
    .pcode_en(pcode_en), .pcode_sat(pcode_sat), .pcode_preg(pcode_preg),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // generator stand-in and its golden model
  function automatic logic [15:0] seed(input logic [5:0] s);
    return {s, 10'h2A5};
  endfunction

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [31:0] gold_word(input logic [5:0] s, input int idx);
    logic [15:0] l;
    logic [31:0] w;
    l = seed(s);
    w = '0;
    for (int k = 0; k < idx * 32; k++) l = step(l);
    for (int b = 0; b < 32; b++) begin
      w = {w[30:0], l[0]};
      l = step(l);
    end
    return w;
  endfunction

  assign pcode_preg = gen_l[0];

  always @(posedge clk) begin
    if (pcode_prn_changed) gen_l <= seed(pcode_sat);
    else if (pcode_en)     gen_l <= step(gen_l);
  end

  // monitor
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back(out_data);
    if (pcode_prn_changed) prn_cnt <= prn_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // driver / checker tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [5:0] s, input logic [23:0] l);
    cmd_sat   = s;
    cmd_len   = l;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic score(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_word"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_pcode_en"}, {31'd0, pcode_en}, 32'd0);
    check({tag, "_prn"}, {31'd0, pcode_prn_changed}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    cmd_t        bad[3];
    int          en_cnt, en_low, first_low, stable_bad, prn0, done0, n;
    logic [31:0] g;
    logic        done_prev, acc_after_done, accepted;

    cmd_valid = 1'b0; cmd_sat = '0; cmd_len = '0; abort = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    check_idle_outputs("reset");
    check("reset_out_data", out_data, 32'd0);
    check("reset_err", {31'd0, err_bad_cmd}, 32'd0);
    check("reset_sat", {26'd0, pcode_sat}, 32'd0);
    @(negedge clk);

    // 1: single word latency
    exp_q.push_back(gold_word(6'd1, 0));
    send_cmd(6'd1, 24'd1);
    check("t1_prn_T1", {31'd0, pcode_prn_changed}, 32'd1);
    check("t1_en_T1", {31'd0, pcode_en}, 32'd0);
    en_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      en_cnt += int'(pcode_en);
    end
    check("t1_en_cycles", en_cnt, 32'd32);
    check("t1_valid_T33", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("t1_valid_T34", {31'd0, out_valid}, 32'd1);
    check("t1_data_T34", out_data, gold_word(6'd1, 0));
    check("t1_en_T34", {31'd0, pcode_en}, 32'd0);
    @(negedge clk);
    check("t1_done_T35", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("t1_ready_T36", {31'd0, cmd_ready}, 32'd1);
    check("t1_done_T36", {31'd0, done}, 32'd0);
    score("t1");

    // 2: backpressure on word 1 stalls the last chip of word 2
    for (int i = 0; i < 3; i++) exp_q.push_back(gold_word(6'd7, i));
    g = gold_word(6'd7, 0);
    send_cmd(6'd7, 24'd3);
    wait_valid("t2");
    out_ready = 1'b0;
    en_low = 0; first_low = -1; stable_bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_data !== g || !out_valid) stable_bad++;
      if (!pcode_en) begin
        en_low++;
        if (first_low < 0) first_low = k;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("t2_stable", stable_bad, 32'd0);
    check("t2_first_stall", first_low, 32'd31);
    check("t2_stall_cycles", en_low, 32'd9);
    wait_done("t2");
    score("t2");

    // 3: rejected commands
    bad[0].sat = 6'd0;  bad[0].len = 24'd1;
    bad[1].sat = 6'd38; bad[1].len = 24'd1;
    bad[2].sat = 6'd5;  bad[2].len = 24'd0;
    prn0 = prn_cnt;
    for (int i = 0; i < 3; i++) begin
      send_cmd(bad[i].sat, bad[i].len);
      check("t3_err_pulse", {31'd0, err_bad_cmd}, 32'd1);
      check("t3_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("t3_err_clear", {31'd0, err_bad_cmd}, 32'd0);
    end
    check("t3_no_prn", prn_cnt, prn0);

    // 4: abort in RUN, then epoch restart
    done0 = done_cnt;
    send_cmd(6'd3, 24'd2);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle_outputs("t4_abort");
    repeat (5) @(negedge clk);
    check("t4_no_done", done_cnt, done0);
    check("t4_no_word", got_q.size(), 32'd0);
    exp_q.push_back(gold_word(6'd5, 0));
    send_cmd(6'd5, 24'd1);
    check("t4_prn", {31'd0, pcode_prn_changed}, 32'd1);
    wait_done("t4");
    score("t4");

    // 5: synchronous reset mid-run with a word pending
    send_cmd(6'd9, 24'd2);
    wait_valid("t5");
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("t5_rst");
    check("t5_out_data", out_data, 32'd0);
    check("t5_sat", {26'd0, pcode_sat}, 32'd0);
    out_ready = 1'b1;
    got_q.delete();
    exp_q.delete();
    @(negedge clk);

    // 6: back-to-back commands, second held while busy
    exp_q.push_back(gold_word(6'd37, 0));
    exp_q.push_back(gold_word(6'd37, 1));
    exp_q.push_back(gold_word(6'd2, 0));
    send_cmd(6'd37, 24'd2);
    cmd_sat = 6'd2; cmd_len = 24'd1; cmd_valid = 1'b1;
    n = 0; done_prev = 1'b0; acc_after_done = 1'b0; accepted = 1'b0;
    while (!accepted && n < 300) begin
      if (cmd_ready) begin
        accepted = 1'b1;
        acc_after_done = done_prev;
      end
      done_prev = done;
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    check("t6_accepted", {31'd0, accepted}, 32'd1);
    check("t6_after_done", {31'd0, acc_after_done}, 32'd1);
    check("t6_prn", {31'd0, pcode_prn_changed}, 32'd1);
    check("t6_sat", {26'd0, pcode_sat}, 32'd2);
    wait_done("t6");
    score("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
